demux_1to4_n: RTL and testbench
===============================

# demux_1to4_n

Registered 1-to-4 demultiplexer with per-channel valid/ready handshake: the write-side counterpart of the `mux_4to1_n` selector. A single n-bit source word is steered by `sel` into one of four one-entry output buffers, so a single producer can feed four independent consumers, e.g. distributing a result bus to four downstream stages. Each output holds its word until the consumer takes it; back-pressure on the selected channel stalls the source.

## Interface
- `n`, 32, data width in bits (≥1)
- `clk`  in  1  rising-edge clock, sole clock domain
- `rst`  in  1  reset, synchronous, active-high
- `src`  in  n  source data word
- `sel`  in  2  destination channel index (0..3)
- `src_valid`  in  1  source offers `src` this cycle
- `src_ready`  out  1  block accepts `src` this cycle (combinational)
- `z0`, `z1`, `z2`, `z3`  out  n  channel data outputs (registered)
- `z_valid`  out  4  bit k: channel k holds an undelivered word
- `z_ready`  in  4  bit k: consumer k takes the word this cycle

## Operation
- Per channel k: data register `zk`, flag `z_valid[k]`; two states, EMPTY (`z_valid[k]`=0) and FULL (`z_valid[k]`=1).
- Accept = `src_valid & src_ready`; drain_k = `z_valid[k] & z_ready[k]`.
- `src_ready` = `!z_valid[sel] | z_ready[sel]`: selected buffer empty, or draining this cycle. Depends only on `sel`, `z_valid`, `z_ready`; never on `src_valid`.
- On accept: `z[sel]` ← `src`, `z_valid[sel]` ← 1 (EMPTY→FULL, or FULL→FULL when a drain occurs in the same cycle).
- On drain_k without a load into k: `z_valid[k]` ← 0 (FULL→EMPTY); `zk` keeps its last value.
- Non-selected channels are unaffected by `src`/`sel`; all four channels drain independently and in parallel.
- `z_ready[k]` while `z_valid[k]`=0: ignored.
- While FULL and not draining, `zk` is stable; it is never overwritten.
- `sel`/`src` changes while `src_valid`=0: no effect.

## Timing
- Reset (`rst`=1 at a rising edge): `z_valid`=4'b0000, `z0`..`z3`=0. `src_ready` then follows its combinational rule (1 out of reset). Reset takes priority over a same-cycle accept or drain; words in flight are discarded.
- Latency: a word accepted at edge t appears on `z[sel]` with `z_valid` high after edge t; the earliest drain is at edge t+1.
- Throughput: one word per cycle to a single channel when its consumer holds `z_ready` high (simultaneous load and drain). Round-robin across channels also sustains one word per cycle.
- Stall: selected channel FULL and `z_ready[sel]`=0 → `src_ready`=0. The source must hold `src`, `sel` and `src_valid` until accepted.
- No combinational path from `src`/`src_valid` to any output.

## Configuration
- `DEMUX_BCAST_EN` defined: adds input port `bcast` (1 bit, after `sel`).
  - When `bcast`=1, `sel` is ignored and `src_ready` = AND over k of (`!z_valid[k] | z_ready[k]`).
  - Accept loads `src` into all four channels and sets `z_valid`=4'b1111.
  - `bcast`=0 behaves exactly as the base block.
- Macro undefined: no `bcast` port; unicast only.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `src_valid`=1 → `z_valid`=0000, `z0..z3`=0, `src_ready`=1.
- Unicast fill: n=32, send 32'h1234/0, 32'h4567/1, 32'h98785/2, 32'h1111/3 on consecutive cycles with `z_ready`=0000 → `z_valid`=1111, each zk holds its word, `src_ready`=0 for every `sel`.
- Back-pressure: channel 2 FULL with 32'hAAAA, offer 32'hBBBB on sel=2 with `z_ready[2]`=0 for 3 cycles → `src_ready`=0 and z2 stays 32'hAAAA. Raise `z_ready[2]` → same cycle accept; z2=32'hBBBB next cycle, `z_valid[2]` stays 1.
- Streaming: sel=1, `z_ready[1]`=1, words 1..8 on 8 consecutive cycles → `src_ready` constantly 1; z1 shows 1..8 on consecutive cycles one cycle later.
- Mid-operation reset: channels 0 and 3 FULL, assert `rst` in the same cycle as an accept to channel 1 → all `z_valid`=0 and data=0 next cycle.
- `DEMUX_BCAST_EN`: `bcast`=1, `src`=32'hCAFE, channel 0 FULL and not ready → stall. Drain channel 0 → accept; all zk=32'hCAFE, `z_valid`=1111.

Source files
------------

// File: rtl/demux_1to4_n.sv
// demux_1to4_n: registered 1-to-4 demultiplexer feeding four one-entry valid/ready buffers.
// Optional DEMUX_BCAST_EN adds a bcast input that loads all four channels in one accept.

module demux_1to4_n_chan #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] din,
  input  logic         ready,
  output logic [n-1:0] data,
  output logic         valid
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (load) data <= din;
    end
  end

  // A load wins over a same-cycle drain, so the buffer stays FULL with the new word.
  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = FULL;
    else if (state == FULL && ready)
      state_nxt = EMPTY;
  end

  assign valid = (state == FULL);
endmodule

module demux_1to4_n #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] src,
  input  logic [1:0]   sel,
`ifdef DEMUX_BCAST_EN
  input  logic         bcast,
`endif
  input  logic         src_valid,
  output logic         src_ready,
  output logic [n-1:0] z0,
  output logic [n-1:0] z1,
  output logic [n-1:0] z2,
  output logic [n-1:0] z3,
  output logic [3:0]   z_valid,
  input  logic [3:0]   z_ready
);
  logic [3:0]        free;
  logic [3:0]        load;
  logic [3:0][n-1:0] zq;
  logic              accept;

  // A channel can take a word if it is empty or its current word leaves this cycle.
  assign free = ~z_valid | z_ready;

`ifdef DEMUX_BCAST_EN
  assign src_ready = bcast ? &free : free[sel];
`else
  assign src_ready = free[sel];
`endif

  assign accept = src_valid & src_ready;

  always_comb begin
    load      = '0;
    load[sel] = accept;
`ifdef DEMUX_BCAST_EN
    if (bcast) load = {4{accept}};
`endif
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    demux_1to4_n_chan #(.n(n)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (src),
      .ready (z_ready[k]),
      .data  (zq[k]),
      .valid (z_valid[k])
    );
  end

  assign z0 = zq[0];
  assign z1 = zq[1];
  assign z2 = zq[2];
  assign z3 = zq[3];
endmodule

// File: tb/tb_demux_1to4_n.sv
// Scoreboard bench for demux_1to4_n: per-channel queues of expected words, filled on accept
// and drained on consumer handshake; scenario tasks compare DUT outputs to the queue heads.
module tb_demux_1to4_n;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src;
  logic [1:0]  sel;
`ifdef DEMUX_BCAST_EN
  logic        bcast;
`endif
  logic        src_valid;
  logic        src_ready;
  logic [31:0] z0, z1, z2, z3;
  logic [3:0]  z_valid;
  logic [3:0]  z_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q [4][$];

  demux_1to4_n #(.n(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .sel       (sel),
`ifdef DEMUX_BCAST_EN
    .bcast     (bcast),
`endif
    .src_valid (src_valid),
    .src_ready (src_ready),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .z_valid   (z_valid),
    .z_ready   (z_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] zout(input int k);
    case (k)
      0: return z0;
      1: return z1;
      2: return z2;
      default: return z3;
    endcase
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (q[k].size() != 0);
    return f;
  endfunction

  function automatic logic exp_ready();
    logic [3:0] fr;
    fr = ~exp_full() | z_ready;
`ifdef DEMUX_BCAST_EN
    if (bcast) return &fr;
`endif
    return fr[sel];
  endfunction

  // Advance one clock and update the scoreboard from the inputs seen at that edge.
  task automatic tick();
    logic [3:0] dr;
    logic       acc;
    @(posedge clk);
    dr  = exp_full() & z_ready;
    acc = src_valid & exp_ready();
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) if (dr[k]) void'(q[k].pop_front());
`ifdef DEMUX_BCAST_EN
      if (acc && bcast) for (int k = 0; k < 4; k++) q[k].push_back(src);
      else
`endif
      if (acc) q[sel].push_back(src);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = 1'b1; src = 32'hFFFF_FFFF; sel = 2'd0; z_ready = 4'b0000;
    tick();
    tick();
    rst = 1'b0; src_valid = 1'b0;
    #1;
    n_cmp++;
    if (z_valid !== 4'b0000) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0000", z_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (zout(k) !== 32'h0) begin
        n_bad++; $display("FAIL reset_z%0d: got %h want 0", k, zout(k));
      end
    end
    n_cmp++;
    if (src_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", src_ready);
    end
  endtask

  task automatic test_fill();
    logic [31:0] words [4];
    words[0] = 32'h1234; words[1] = 32'h4567; words[2] = 32'h98785; words[3] = 32'h1111;
    z_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      src = words[i]; sel = 2'(i); src_valid = 1'b1;
      #1;
      n_cmp++;
      if (src_ready !== exp_ready()) begin
        n_bad++; $display("FAIL fill_ready%0d: got %b want %b", i, src_ready, exp_ready());
      end
      tick();
    end
    src_valid = 1'b0;
    #1;
    n_cmp++;
    if (z_valid !== exp_full()) begin
      n_bad++; $display("FAIL fill_valid: got %b want %b", z_valid, exp_full());
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (q[k].size() == 0 || zout(k) !== q[k][0] || zout(k) !== words[k]) begin
        n_bad++; $display("FAIL fill_z%0d: got %h want %h", k, zout(k), words[k]);
      end
      sel = 2'(k);
      #1;
      n_cmp++;
      if (src_ready !== 1'b0) begin
        n_bad++; $display("FAIL fill_stall%0d: got %b want 0", k, src_ready);
      end
    end
    z_ready = 4'b1111;
    tick();
    z_ready = 4'b0000;
    #1;
    n_cmp++;
    if (z_valid !== 4'b0000) begin
      n_bad++; $display("FAIL fill_drain: got %b want 0000", z_valid);
    end
  endtask

  task automatic test_backpressure();
    z_ready = 4'b0000; sel = 2'd2; src = 32'hAAAA; src_valid = 1'b1;
    tick();
    src = 32'hBBBB;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (src_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_stall%0d: got %b want 0", c, src_ready);
      end
      n_cmp++;
      if (z2 !== q[2][0] || z2 !== 32'hAAAA) begin
        n_bad++; $display("FAIL bp_hold%0d: got %h want aaaa", c, z2);
      end
      tick();
    end
    z_ready = 4'b0100;
    #1;
    n_cmp++;
    if (src_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got %b want 1", src_ready);
    end
    tick();
    src_valid = 1'b0; z_ready = 4'b0000;
    #1;
    n_cmp++;
    if (z2 !== q[2][0] || z2 !== 32'hBBBB || z_valid[2] !== 1'b1) begin
      n_bad++; $display("FAIL bp_reload: got %h/%b want bbbb/1", z2, z_valid[2]);
    end
    z_ready = 4'b0100;
    tick();
    z_ready = 4'b0000;
  endtask

  task automatic test_stream();
    sel = 2'd1; z_ready = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      src = 32'(i); src_valid = 1'b1;
      #1;
      n_cmp++;
      if (src_ready !== 1'b1) begin
        n_bad++; $display("FAIL stream_ready%0d: got %b want 1", i, src_ready);
      end
      if (i > 1) begin
        n_cmp++;
        if (z_valid[1] !== 1'b1 || z1 !== q[1][0] || z1 !== 32'(i - 1)) begin
          n_bad++; $display("FAIL stream_z1_%0d: got %h want %h", i, z1, i - 1);
        end
      end
      tick();
    end
    src_valid = 1'b0;
    #1;
    n_cmp++;
    if (z1 !== 32'd8 || z_valid[1] !== 1'b1) begin
      n_bad++; $display("FAIL stream_last: got %h/%b want 8/1", z1, z_valid[1]);
    end
    tick();
    z_ready = 4'b0000;
  endtask

  task automatic test_round_robin();
    z_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4); src = 32'hC000 + 32'(i); src_valid = 1'b1;
      #1;
      n_cmp++;
      if (src_ready !== exp_ready()) begin
        n_bad++; $display("FAIL rr_ready%0d: got %b want %b", i, src_ready, exp_ready());
      end
      tick();
      n_cmp++;
      if (zout(i % 4) !== src || z_valid !== exp_full()) begin
        n_bad++; $display("FAIL rr_z%0d: got %h/%b want %h/%b", i, zout(i % 4), z_valid, src, exp_full());
      end
    end
    src_valid = 1'b0;
    tick();
    z_ready = 4'b0000;
  endtask

  task automatic test_mid_reset();
    z_ready = 4'b0000; src_valid = 1'b1;
    sel = 2'd0; src = 32'h100; tick();
    sel = 2'd3; src = 32'h300; tick();
    sel = 2'd1; src = 32'h111; rst = 1'b1;
    tick();
    rst = 1'b0; src_valid = 1'b0;
    #1;
    n_cmp++;
    if (z_valid !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_valid: got %b want 0000", z_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (zout(k) !== 32'h0) begin
        n_bad++; $display("FAIL midrst_z%0d: got %h want 0", k, zout(k));
      end
    end
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    z_ready = 4'b0000; bcast = 1'b0; sel = 2'd0; src = 32'h5555; src_valid = 1'b1;
    tick();
    bcast = 1'b1; sel = 2'd2; src = 32'hCAFE;
    #1;
    n_cmp++;
    if (src_ready !== 1'b0) begin
      n_bad++; $display("FAIL bcast_stall: got %b want 0", src_ready);
    end
    tick();
    n_cmp++;
    if (z0 !== 32'h5555 || z_valid !== 4'b0001) begin
      n_bad++; $display("FAIL bcast_hold: got %h/%b want 5555/0001", z0, z_valid);
    end
    z_ready = 4'b0001;
    #1;
    n_cmp++;
    if (src_ready !== 1'b1) begin
      n_bad++; $display("FAIL bcast_release: got %b want 1", src_ready);
    end
    tick();
    src_valid = 1'b0; bcast = 1'b0; z_ready = 4'b0000;
    #1;
    n_cmp++;
    if (z_valid !== 4'b1111) begin
      n_bad++; $display("FAIL bcast_valid: got %b want 1111", z_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (zout(k) !== 32'hCAFE || zout(k) !== q[k][0]) begin
        n_bad++; $display("FAIL bcast_z%0d: got %h want cafe", k, zout(k));
      end
    end
    z_ready = 4'b1111;
    tick();
    z_ready = 4'b0000;
  endtask
`endif

  initial begin
`ifdef DEMUX_BCAST_EN
    bcast = 1'b0;
`endif
    test_reset();
    test_fill();
    test_backpressure();
    test_stream();
    test_round_robin();
    test_mid_reset();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
